seq_multiplier_32bit: RTL and testbench
=======================================

# seq_multiplier_32bit

Multi-cycle 32×32→64 shift-and-add multiplier for the MIPS ALU's `mult`/`multu` path. It is the addition-side counterpart of the datapath's subtractor/divider and writes the HI/LO pair. It runs one add-and-shift iteration per clock through a single 32-bit carry-lookahead adder. It exposes a start/busy/done handshake so the control unit can stall until HI/LO are valid.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `signed_op`  in  1  1 = `mult` (two's complement), 0 = `multu`. Sampled with `start`.
- `a`  in  32  multiplicand. Sampled with `start`.
- `b`  in  32  multiplier. Sampled with `start`.
- `busy`  out  1  high in RUN and SIGN.
- `done`  out  1  one-cycle pulse when `hi`/`lo` become valid.
- `hi`  out  32  product bits [63:32], registered.
- `lo`  out  32  product bits [31:0], registered.

## Operation
- **States:** IDLE, RUN, SIGN. Reset state is IDLE.
- **IDLE with `start`=1:**
  - latch `|a|` into `mcand` and `|b|` into the low half of `acc`; the upper half of `acc` is 0.
  - latch `neg = signed_op & (a[31] ^ b[31])`.
  - `count` = 0; go to RUN.
  - Absolute value applies only when `signed_op`=1. `|0x80000000|` = `0x80000000`, read as unsigned.
- **RUN, once per cycle:**
  - if `acc[0]`=1, `sum = acc[63:32] + mcand` (33 bits including carry-out); otherwise `sum = {1'b0, acc[63:32]}`.
  - `acc <= {sum, acc[31:1]}` (logical right shift that keeps the carry).
  - `count++`. When `count`=31 at the edge, go to SIGN.
- **SIGN:**
  - `{hi,lo} <= neg ? (~acc + 1) : acc` (64-bit two's-complement negate).
  - `done` <= 1; go to IDLE.
- `start` in RUN or SIGN is ignored: no queuing, and operands are not re-sampled.
- `start` in the cycle `done`=1 is accepted, because the FSM is already in IDLE.
- `hi`/`lo` hold their value until the next SIGN; they are not cleared by `start`.
- **Reset at any point:**
  - state = IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, `count`=0, `acc`=0.
  - an in-flight product is discarded; no `done` is produced.
- Zero operands take the full latency; there is no early termination.

## Timing
- Edge E0 samples `start`=1 in IDLE → `busy`=1 from the cycle after E0.
- Edges E1..E32 perform the 32 RUN iterations.
- Edge E33 (SIGN) → `done`=1 and `hi`/`lo` valid in the cycle after E33. At the same edge `busy` drops to 0.
- Latency is 34 clocks from the start-sampling edge to `done` visible. Throughput is one product per 34 cycles.
- Back-to-back: `start` held high during the `done` cycle is sampled at E34, so the next product's `done` follows 34 clocks later.
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0.
- **Reset priority:** `reset` overrides `start` in the same cycle.
- **Critical path:** one 32-bit carry-lookahead add plus a mux in RUN. The 64-bit negate in SIGN is its own cycle.

## Structure
- Shared ALU package holds:
  - state encoding `mul_state_t` {IDLE, RUN, SIGN}.
  - `MUL_WIDTH`=32 and `MUL_ITERS`=32.
- Sub-module: instantiate the existing `CarryLookaheadAdder32Bit`, with carry-in 0 and carry-out used as `sum[32]`, for the partial-product add. Use a second instance (or a generic add) for the low/high halves of the 64-bit negate and abs.
- No other sub-modules. FSM, counter and `acc` live in this block.

## Test plan
- Unsigned: `multu` a=`0xFFFFFFFF`, b=`0xFFFFFFFF` → `done` 34 clocks after start; `hi`=`0xFFFFFFFE`, `lo`=`0x00000001`; `busy` high for exactly 33 cycles.
- Signed mixed: `mult` a=`0xFFFFFFFD` (-3), b=7 → `hi`=`0xFFFFFFFF`, `lo`=`0xFFFFFFEB` (-21).
- Signed corner: `mult` a=b=`0x80000000` → `hi`=`0x40000000`, `lo`=0. `multu` on the same operands gives the same result. `mult` with a=`0x80000000`, b=1 → `hi`=`0xFFFFFFFF`, `lo`=`0x80000000`.
- Handshake:
  - `start` pulsed in RUN with new operands → ignored; first result `multu` 6×7 → `lo`=42, `hi`=0.
  - `start` held through `done` → second product `multu` 3×5 → `lo`=15, accepted at the `done` edge; second `done` 34 clocks later.
- Reset mid-op: assert `reset` at RUN iteration 10 → next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse. A fresh `multu` 2×2 then yields `lo`=4.
- Random: 1000 random `mult`/`multu` pairs checked against a 64-bit reference product, with random idle gaps of 0–3 cycles between starts.

Source files
------------

// File: rtl/seq_multiplier_32bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_32bit_pkg
// Description : Shared ALU definitions for the sequential multiplier: the
//               FSM state encoding, operand width, iteration count and an
//               absolute-value helper used when latching operands.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_multiplier_32bit_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } mul_state_t;

    // Magnitude of a two's-complement operand when the signed flag is set;
    // unsigned operands pass through. 0x80000000 maps to itself, which is
    // the correct magnitude once read as unsigned.
    function automatic logic [MUL_WIDTH-1:0] abs_if_signed(
        input logic [MUL_WIDTH-1:0] value,
        input logic                 is_signed
    );
        if (is_signed && value[MUL_WIDTH-1]) begin
            return (~value) + {{(MUL_WIDTH-1){1'b0}}, 1'b1};
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_32bit_cla.sv
`default_nettype none
// ============================================================================
// Module      : CarryLookaheadAdder32Bit
// Description : 32-bit two-level carry-lookahead adder. Bits are grouped in
//               fours; each group produces generate/propagate terms, the
//               group carries are resolved from those, and the carries inside
//               a group are expanded directly from the group carry-in.
// Ports       : a, b  - 32-bit addends
//               cin   - carry in
//               sum   - 32-bit sum
//               cout  - carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module CarryLookaheadAdder32Bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [7:0]  w_grp_g;
    logic [7:0]  w_grp_p;
    logic [7:0]  w_grp_c;
    logic        w_carry_out;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group generate/propagate terms, one per 4-bit slice.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_group_terms
            assign w_grp_g[gi] = w_g[4*gi+3]
                               | (w_p[4*gi+3] & w_g[4*gi+2])
                               | (w_p[4*gi+3] & w_p[4*gi+2] & w_g[4*gi+1])
                               | (w_p[4*gi+3] & w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi]);
            assign w_grp_p[gi] = &w_p[4*gi +: 4];
        end
    endgenerate

    // Second-level lookahead: carry into every group from the group terms.
    always_comb begin
        logic v_carry;
        v_carry = cin;
        w_grp_c = '0;
        for (int k = 0; k < 8; k++) begin
            w_grp_c[k] = v_carry;
            v_carry    = w_grp_g[k] | (w_grp_p[k] & v_carry);
        end
        w_carry_out = v_carry;
    end

    // Carries inside each group, flattened from the group carry-in.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit_carries
            assign w_c[4*gi]   = w_grp_c[gi];
            assign w_c[4*gi+1] = w_g[4*gi]
                               | (w_p[4*gi] & w_grp_c[gi]);
            assign w_c[4*gi+2] = w_g[4*gi+1]
                               | (w_p[4*gi+1] & w_g[4*gi])
                               | (w_p[4*gi+1] & w_p[4*gi] & w_grp_c[gi]);
            assign w_c[4*gi+3] = w_g[4*gi+2]
                               | (w_p[4*gi+2] & w_g[4*gi+1])
                               | (w_p[4*gi+2] & w_p[4*gi+1] & w_g[4*gi])
                               | (w_p[4*gi+2] & w_p[4*gi+1] & w_p[4*gi] & w_grp_c[gi]);
        end
    endgenerate

    assign sum  = w_p ^ w_c;
    assign cout = w_carry_out;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_32bit.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_32bit
// Description : Multi-cycle 32x32->64 shift-and-add multiplier for the
//               mult/multu path. Operand magnitudes are multiplied unsigned
//               over 32 add-and-shift iterations, then a separate cycle
//               applies the result sign and writes HI/LO.
// Ports       : clock     - rising-edge clock
//               reset     - synchronous active-high reset
//               start     - request, sampled only in IDLE
//               signed_op - 1 = mult (two's complement), 0 = multu
//               a, b      - multiplicand / multiplier, sampled with start
//               busy      - high while a product is in flight (RUN, SIGN)
//               done      - one-cycle pulse when hi/lo become valid
//               hi, lo    - registered product bits [63:32] / [31:0]
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_32bit
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [MUL_CNT_W-1:0] c_last_iter = MUL_CNT_W'(MUL_ITERS - 1);

    mul_state_t             r_state;
    mul_state_t             w_next_state;

    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mcand;
    logic                   r_neg;
    logic [MUL_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_done;

    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_neg_acc;
    logic                   w_neg_lo_cout;
    logic                   w_neg_cout_unused;

    // ------------------------------------------------------------------
    // Partial-product adder: the multiplicand is gated by the current
    // multiplier bit so the adder input itself forms the add/no-add mux.
    // ------------------------------------------------------------------
    assign w_addend = r_acc[0] ? r_mcand : '0;

    CarryLookaheadAdder32Bit u_pp_add (
        .a    (r_acc[2*WIDTH-1:WIDTH]),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum[WIDTH-1:0]),
        .cout (w_sum[WIDTH])
    );

    // ------------------------------------------------------------------
    // 64-bit negate (~acc + 1) as two chained 32-bit adds. The final
    // carry-out only fires for a zero product and carries no information.
    // ------------------------------------------------------------------
    CarryLookaheadAdder32Bit u_neg_lo (
        .a    (~r_acc[WIDTH-1:0]),
        .b    ('0),
        .cin  (1'b1),
        .sum  (w_neg_acc[WIDTH-1:0]),
        .cout (w_neg_lo_cout)
    );

    CarryLookaheadAdder32Bit u_neg_hi (
        .a    (~r_acc[2*WIDTH-1:WIDTH]),
        .b    ('0),
        .cin  (w_neg_lo_cout),
        .sum  (w_neg_acc[2*WIDTH-1:WIDTH]),
        .cout (w_neg_cout_unused)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_count == c_last_iter) begin
                    w_next_state = SIGN;
                end
            end
            SIGN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, add-and-shift iterations, sign fix-up.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= abs_if_signed(a, signed_op);
                        r_acc   <= {{WIDTH{1'b0}}, abs_if_signed(b, signed_op)};
                        r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_count <= '0;
                    end
                end
                RUN: begin
                    // The 33-bit sum keeps the carry as the new MSB while the
                    // consumed multiplier bit falls off the bottom.
                    r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                end
                SIGN: begin
                    {r_hi, r_lo} <= r_neg ? w_neg_acc : r_acc;
                    r_done       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == RUN) || (r_state == SIGN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier_32bit
// Description : Self-checking bench for seq_multiplier_32bit. Directed
//               handshake, corner and reset scenarios followed by randomized
//               mult/multu operations compared against a 64-bit arithmetic
//               reference product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier_32bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    // Reference: the full 64-bit product, signed or unsigned.
    function automatic logic [63:0] ref_product(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns 1 ns after the sampling edge with
    // start dropped and the operand inputs scrambled.
    task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y);
        signed_op = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        signed_op = 1'($urandom_range(0, 1));
    endtask

    // edges counts clock edges from the sampling edge (as 1) to the edge
    // after which done is seen; returns at the falling edge where done is 1.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 1;
        busy_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) busy_cyc++;
            if (done) return;
            @(posedge clock);
            edges++;
        end
        @(negedge clock);
        edges = -1;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expected);
        int e;
        int bc;
        start_op(s, x, y);
        wait_done(e, bc);
        check({tag, " latency"}, 64'(e), 64'd34);
        check({tag, " product"}, {hi, lo}, expected);
    endtask

    initial begin
        int          e;
        int          bc;
        int          pulses;
        logic [31:0] corners [5];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        // Reset state
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Unsigned max x max with latency and busy width
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(e, bc);
        check("umax latency", 64'(e), 64'd34);
        check("umax busy cycles", 64'(bc), 64'd33);
        check("umax product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clock);
        check("done pulse width", 64'(done), 64'd0);
        check("idle after done", 64'(busy), 64'd0);

        // Signed mixed and corner cases
        run_op("mult -3*7", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("multu min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("mult min*1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

        // start pulsed during RUN with new operands is ignored
        start_op(1'b0, 32'd6, 32'd7);
        repeat (5) @(negedge clock);
        signed_op = 1'b1; a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(e, bc);
        check("ignored start latency", 64'(e), 64'd29);
        check("ignored start product", {hi, lo}, 64'd42);
        @(negedge clock);
        check("ignored start not queued", 64'(busy), 64'd0);

        // start held through the done cycle is accepted back-to-back
        start_op(1'b0, 32'd11, 32'd13);
        wait_done(e, bc);
        check("b2b first product", {hi, lo}, 64'd143);
        start_op(1'b0, 32'd3, 32'd5);
        wait_done(e, bc);
        check("b2b second latency", 64'(e), 64'd34);
        check("b2b second product", {hi, lo}, 64'd15);

        // Reset at RUN iteration 10 discards the product
        start_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (10) @(negedge clock);
        check("hold hi/lo during run", {hi, lo}, 64'd15);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midop reset busy", 64'(busy), 64'd0);
        check("midop reset done", 64'(done), 64'd0);
        check("midop reset hi/lo", {hi, lo}, 64'd0);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("no done after reset", 64'(pulses), 64'd0);
        run_op("post reset 2*2", 1'b0, 32'd2, 32'd2, 64'd4);

        // Randomized operations with idle gaps of 0-3 cycles
        for (int n = 0; n < 1000; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_op($sformatf("rand[%0d] s=%0d a=%h b=%h", n, rs, ra, rb), rs, ra, rb,
                   ref_product(rs, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
